// File: rtl/sixteen_to_one_tdm_mux_pkg.sv
// rtl/sixteen_to_one_tdm_mux_pkg.sv - shared sizes and FSM state type for the 16:1 TDM mux
package tdm_mux_pkg;
   localparam int N_CH  = 16;
   localparam int SEL_W = $clog2(N_CH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      MANUAL = 2'd2
   } state_t;
endpackage

// File: rtl/sixteen_to_one_tdm_mux_if.sv
// rtl/sixteen_to_one_tdm_mux_if.sv - channel inputs and beat handshake bundle of the 16:1 TDM mux
interface sixteen_to_one_tdm_mux_if;
   import tdm_mux_pkg::*;

   logic             en;
   logic             mode_manual;
   logic [SEL_W-1:0] man_sel;
   logic [N_CH-1:0]  ch_in;
   logic [N_CH-1:0]  ch_mask;
   logic             out_ready;
   logic             out_valid;
   logic             out_bit;
   logic [SEL_W-1:0] out_sel;
   logic             frame_start;
   logic             busy;

   modport master (
      output en, mode_manual, man_sel, ch_in, ch_mask, out_ready,
      input  out_valid, out_bit, out_sel, frame_start, busy
   );

   modport slave (
      input  en, mode_manual, man_sel, ch_in, ch_mask, out_ready,
      output out_valid, out_bit, out_sel, frame_start, busy
   );
endinterface

// File: rtl/sixteen_to_one_tdm_mux_next_ch.sv
// rtl/sixteen_to_one_tdm_mux_next_ch.sv - priority search for the next enabled channel
module tdm_next_ch
   import tdm_mux_pkg::*;
(
   input  logic [N_CH-1:0]  i_mask,
   input  logic [SEL_W-1:0] i_cur,
   input  logic             i_first,
   output logic [SEL_W-1:0] o_nxt,
   output logic             o_none
);

   // Walking downwards lets the lowest qualifying bit win the last assignment.
   always_comb begin
      o_nxt  = '0;
      o_none = 1'b1;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (i_mask[i] && (i_first || (SEL_W'(i) > i_cur))) begin
            o_nxt  = SEL_W'(i);
            o_none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sixteen_to_one_tdm_mux.sv
// rtl/sixteen_to_one_tdm_mux.sv - framed 16:1 time-division multiplexer with manual select mode
module sixteen_to_one_tdm_mux
   import tdm_mux_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   sixteen_to_one_tdm_mux_if.slave  io_bus
);

   state_t           r_state;
   logic [N_CH-1:0]  r_snap_d;
   logic [N_CH-1:0]  r_snap_m;
   logic             r_out_valid;
   logic             r_out_bit;
   logic [SEL_W-1:0] r_out_sel;
   logic             r_frame_start;
   logic             r_busy;

   logic [SEL_W-1:0] w_first_sel;
   logic             w_first_none;
   logic [SEL_W-1:0] w_adv_sel;
   logic             w_adv_none;
   logic             w_accept;
   logic             w_start_frame;

   // First beat of a fresh frame is searched on the live mask, advancing on the snapshot.
   tdm_next_ch u_first (
      .i_mask  (io_bus.ch_mask),
      .i_cur   ('0),
      .i_first (1'b1),
      .o_nxt   (w_first_sel),
      .o_none  (w_first_none)
   );

   tdm_next_ch u_adv (
      .i_mask  (r_snap_m),
      .i_cur   (r_out_sel),
      .i_first (1'b0),
      .o_nxt   (w_adv_sel),
      .o_none  (w_adv_none)
   );

   assign w_accept      = r_out_valid & io_bus.out_ready;
   assign w_start_frame = io_bus.en & ~w_first_none;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= IDLE;
         r_snap_d      <= '0;
         r_snap_m      <= '0;
         r_out_valid   <= 1'b0;
         r_out_bit     <= 1'b0;
         r_out_sel     <= '0;
         r_frame_start <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (io_bus.mode_manual) begin
                  r_state <= MANUAL;
                  r_busy  <= 1'b1;
               end else if (w_start_frame) begin
                  r_snap_d      <= io_bus.ch_in;
                  r_snap_m      <= io_bus.ch_mask;
                  r_out_valid   <= 1'b1;
                  r_out_sel     <= w_first_sel;
                  r_out_bit     <= io_bus.ch_in[w_first_sel];
                  r_frame_start <= 1'b1;
                  r_state       <= SCAN;
                  r_busy        <= 1'b1;
               end
            end

            SCAN: begin
               if (w_accept) begin
                  if (!w_adv_none) begin
                     r_out_sel     <= w_adv_sel;
                     r_out_bit     <= r_snap_d[w_adv_sel];
                     r_frame_start <= 1'b0;
                  end else if (w_start_frame) begin
                     r_snap_d      <= io_bus.ch_in;
                     r_snap_m      <= io_bus.ch_mask;
                     r_out_sel     <= w_first_sel;
                     r_out_bit     <= io_bus.ch_in[w_first_sel];
                     r_frame_start <= 1'b1;
                  end else begin
                     r_out_valid   <= 1'b0;
                     r_frame_start <= 1'b0;
                     r_state       <= IDLE;
                     r_busy        <= 1'b0;
                  end
               end
            end

            MANUAL: begin
               if (!io_bus.mode_manual) begin
                  r_out_valid   <= 1'b0;
                  r_frame_start <= 1'b0;
                  r_state       <= IDLE;
                  r_busy        <= 1'b0;
               end else begin
                  r_out_bit     <= io_bus.ch_in[io_bus.man_sel];
                  r_out_sel     <= io_bus.man_sel;
                  r_out_valid   <= 1'b1;
                  r_frame_start <= 1'b0;
               end
            end

            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.out_valid   = r_out_valid;
   assign io_bus.out_bit     = r_out_bit;
   assign io_bus.out_sel     = r_out_sel;
   assign io_bus.frame_start = r_frame_start;
   assign io_bus.busy        = r_busy;

endmodule

// File: tb/tb_sixteen_to_one_tdm_mux.sv
// tb/tb_sixteen_to_one_tdm_mux.sv - randomized and directed bench for the 16:1 TDM mux
module tb_sixteen_to_one_tdm_mux;
   import tdm_mux_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   sixteen_to_one_tdm_mux_if bus ();

   sixteen_to_one_tdm_mux dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference: a frame is the ordered list of enabled channels with their captured bits.
   int   m_mode;        // 0 idle, 1 framing, 2 manual
   int   q_sel[$];
   logic q_bit[$];
   logic e_valid, e_bit, e_fs, e_busy;
   logic [3:0] e_sel;

   task automatic model_reset();
      m_mode = 0; q_sel.delete(); q_bit.delete();
      e_valid = 0; e_bit = 0; e_sel = 0; e_fs = 0; e_busy = 0;
   endtask

   task automatic load_frame();
      q_sel.delete(); q_bit.delete();
      for (int i = 0; i < 16; i++)
         if (bus.ch_mask[i]) begin
            q_sel.push_back(i);
            q_bit.push_back(bus.ch_in[i]);
         end
      e_sel = 4'(q_sel.pop_front());
      e_bit = q_bit.pop_front();
      e_fs = 1; e_valid = 1;
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         model_reset();
         return;
      end
      case (m_mode)
         0: if (bus.mode_manual) begin
               m_mode = 2; e_busy = 1;
            end else if (bus.en && bus.ch_mask != 0) begin
               load_frame(); m_mode = 1; e_busy = 1;
            end
         1: if (e_valid && bus.out_ready) begin
               if (q_sel.size() > 0) begin
                  e_sel = 4'(q_sel.pop_front()); e_bit = q_bit.pop_front(); e_fs = 0;
               end else if (bus.en && bus.ch_mask != 0) begin
                  load_frame();
               end else begin
                  e_valid = 0; e_fs = 0; m_mode = 0; e_busy = 0;
               end
            end
         default: if (!bus.mode_manual) begin
               e_valid = 0; e_fs = 0; m_mode = 0; e_busy = 0;
            end else begin
               e_bit = bus.ch_in[bus.man_sel]; e_sel = bus.man_sel; e_valid = 1; e_fs = 0;
            end
      endcase
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
      chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      if (e_valid || !rst_n) begin
         chk("out_sel", 32'(bus.out_sel), 32'(e_sel));
         chk("out_bit", 32'(bus.out_bit), 32'(e_bit));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic wait_idle();
      bus.en = 0; bus.mode_manual = 0; bus.out_ready = 1;
      for (int k = 0; k < 40 && m_mode != 0; k++) step();
      step();
      chk("idle_timeout", 32'(m_mode), 32'd0);
   endtask

   task automatic run_to_sel(input int s);
      for (int k = 0; k < 40 && !(e_valid && e_sel == 4'(s) && m_mode == 1); k++) step();
      chk("reach_sel", 32'(e_sel), 32'(s));
   endtask

   initial begin
      rst_n = 0;
      bus.en = 0; bus.mode_manual = 0; bus.man_sel = 0;
      bus.ch_in = 0; bus.ch_mask = 0; bus.out_ready = 0;
      model_reset();
      step(); step();
      rst_n = 1;
      step();

      // back-to-back full frames of A5A5
      bus.ch_mask = 16'hFFFF; bus.ch_in = 16'hA5A5; bus.out_ready = 1; bus.en = 1;
      for (int k = 0; k < 34; k++) step();
      wait_idle();

      // sparse mask, data change mid-frame must not leak in
      bus.ch_mask = 16'h8421; bus.ch_in = 16'hFFFF; bus.en = 1;
      step();
      bus.ch_in = 16'h0000;
      for (int k = 0; k < 3; k++) step();
      bus.en = 0;
      step(); step();

      // backpressure at sel 2
      bus.ch_mask = 16'hFFFF; bus.ch_in = 16'h0004; bus.en = 1; bus.out_ready = 1;
      run_to_sel(2);
      bus.out_ready = 0;
      for (int k = 0; k < 3; k++) step();
      bus.out_ready = 1;
      step(); step();
      wait_idle();

      // empty mask stays idle, then single-channel frames
      bus.ch_mask = 16'h0000; bus.en = 1;
      for (int k = 0; k < 4; k++) step();
      bus.ch_mask = 16'h0002; bus.ch_in = 16'h0002;
      for (int k = 0; k < 5; k++) step();
      wait_idle();

      // manual mode, ready ignored
      bus.mode_manual = 1; bus.man_sel = 4'b1010; bus.out_ready = 0; bus.ch_in = 0;
      for (int k = 0; k < 8; k++) begin
         bus.ch_in[10] = ~bus.ch_in[10];
         step();
      end
      wait_idle();

      // asynchronous reset mid-frame at sel 7
      bus.ch_mask = 16'hFFFF; bus.ch_in = 16'hFFFF; bus.en = 1;
      run_to_sel(7);
      #2 rst_n = 0;
      model_reset();
      #1 check_all();
      step();
      rst_n = 1; bus.en = 0;
      step(); step();

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         bus.en        = ($urandom_range(0, 7) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.ch_in     = 16'($urandom);
         bus.ch_mask   = ($urandom_range(0, 3) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'($urandom);
         bus.man_sel   = 4'($urandom);
         if ($urandom_range(0, 19) == 0) bus.mode_manual = ~bus.mode_manual;
         step();
      end
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
